data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Data memory behind the SEQ memory stage. Consumes addr/val_write/wrEn/reEn from the memory-stage control.
//  Performs 64-bit little-endian byte-addressed loads and stores against an internal word array.
//  Split (misaligned) accesses take two word cycles, with a req/busy/done handshake.
//  Returns valM to write-back and flags dmem_error, which feeds status generation.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 64-bit words; power of 2; byte space = DEPTH_WORDS*8
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  req         in   1   access request strobe; sampled only when busy=0
//  wrEn        in   1   store request (qualified by req)
//  reEn        in   1   load request (qualified by req)
//  addr        in   64  byte address of the 8-byte access
//  val_write   in   64  store data; byte k goes to addr+k
//  valM        out  64  load data; valid when done=1, held until the next done
//  done        out  1   one-cycle completion pulse
//  busy        out  1   high while state != IDLE
//  dmem_error  out  1   valid with done; high = access rejected
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; valM=0, done=0, busy=0, dmem_error=0. Memory contents are not cleared.
//  - States: IDLE, W0, W1. Accept = (req & busy=0 & (wrEn|reEn)) at an edge E0.
//  - At accept, latch addr, val_write, op. Word index w = addr[..:3]; offset o = addr[2:0].
//  - Error check at accept:
//    - wrEn&reEn both set -> error.
//    - addr+7 >= DEPTH_WORDS*8 -> error. Compute the sum at 65 bits and treat any set upper bit as out of range.
//    - Error path: go to W0 with no memory access. At E1: done=1, dmem_error=1, valM=0, go to IDLE.
//  - W0 (edge E1): access word w, byte lanes o..7.
//    - Store: byte-merge val_write bytes 0..7-o into lanes o..7.
//    - Load: place lanes o..7 into valM bytes 0..7-o.
//    - If o==0: done=1 at E1, go to IDLE. Otherwise go to W1.
//  - W1 (edge E2): access word w+1, lanes 0..o-1, mapped to val bytes 8-o..7. Then done=1, go to IDLE.
//  - Latency from accept edge: aligned access or error = 1 cycle; split access = 2 cycles.
//  - done and dmem_error are pulses: cleared on the cycle after they assert.
//  - valM is updated only by a successful load; stores leave valM unchanged.
//  - req while busy=1 is ignored, not queued. req with wrEn=reEn=0 is ignored: no done pulse.
//  - Reset during W1: the W0 half of a split store stays written. No done pulse is produced.
//  - Reads of never-written words return X in simulation; the bench must not depend on them.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN
//    Defined: o!=0 is an error, handled identically to out-of-range (1-cycle done, no access). W1 is never entered.
//    Undefined: misaligned accesses are legal and split over W0/W1 as above.
// TESTING
//  1. Assert reset mid-cycle with req high -> valM=0, done=0, busy=0, dmem_error=0 immediately (asynchronous).
//  2. Store 0x0123456789ABCDEF @0x40, then load @0x40.
//     -> each: done exactly 1 cycle after accept; load valM=0x0123456789ABCDEF; dmem_error=0.
//  3. Store 0x1122334455667788 @0x43 (done 2 cycles after accept); load @0x43; load @0x40.
//     -> @0x43 valM=0x1122334455667788; @0x40 valM=0x4455667788ABCDEF.
//  4. Store @0x1FFC (DEPTH_WORDS=1024), then load @0x1FF8.
//     -> store: done+dmem_error after 1 cycle; load returns the prior contents of @0x1FF8.
//     -> Also: wrEn=reEn=1 @0x40 -> error; 0x40 unchanged.
//  5. req pulsed again while busy during a split access -> ignored: single done pulse.
//     -> Then reset asserted in W1 -> IDLE, no done; a load @0x40 after reset shows W0 bytes updated.
//  6. With DMEM_ALIGN_CHECK_EN: load @0x43 -> done+dmem_error after 1 cycle, valM=0, busy for 1 cycle only.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: 64-bit little-endian byte-addressed data memory for the SEQ memory stage
//
// Purpose:
//    Performs 8-byte loads and stores against an internal word array. Aligned
//    accesses and rejected accesses complete one cycle after accept. Misaligned
//    accesses are split over two word cycles (W0, then W1).
//
// Ports:
//    clk         in   1   clock, rising edge
//    reset       in   1   asynchronous, active-low reset
//    req         in   1   access strobe, sampled only while busy=0
//    wrEn        in   1   store request, qualified by req
//    reEn        in   1   load request, qualified by req
//    addr        in   64  byte address of the access
//    val_write   in   64  store data, byte k goes to addr+k
//    valM        out  64  load data, valid with done and held until the next done
//    done        out  1   one-cycle completion pulse
//    busy        out  1   high while an access is in flight
//    dmem_error  out  1   valid with done, high when the access was rejected
//
// Configuration:
//    DMEM_ALIGN_CHECK_EN  when defined, a misaligned address is rejected
//                         instead of being split.
module data_memory_ctrl #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wrEn,
   input  logic        reEn,
   input  logic [63:0] addr,
   input  logic [63:0] val_write,
   output logic [63:0] valM,
   output logic        done,
   output logic        busy,
   output logic        dmem_error
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, W0, W1} state_t;
   state_t r_state, w_next;
   logic [63:0] r_mem [DEPTH_WORDS];
   logic [AW+2:0] r_addr;
   logic [63:0] r_wdata, r_lo;
   logic r_wr, r_err;
   logic w_accept, w_err, w_split;
   logic [64:0] w_end;
   logic [AW-1:0] w_idx;
   logic [5:0] w_sh, w_shc;
   logic [63:0] w_rd, w_mask, w_wval;
   assign busy = r_state != IDLE;
   assign w_accept = req & ~busy & (wrEn | reEn);
   // 65-bit end address so that a wrap past 2^64 still lands out of range
   assign w_end = {1'b0, addr} + 65'd7;
`ifdef DMEM_ALIGN_CHECK_EN
   assign w_err = (wrEn & reEn) | (|(w_end >> (AW + 3))) | (|addr[2:0]);
`else
   assign w_err = (wrEn & reEn) | (|(w_end >> (AW + 3)));
`endif
   assign w_split = |r_addr[2:0];
   assign w_sh = {r_addr[2:0], 3'b000};
   // 64 - 8*o modulo 64; only used in W1 where o != 0
   assign w_shc = 6'd0 - w_sh;
   assign w_idx = r_addr[AW+2:3] + {{(AW-1){1'b0}}, r_state == W1};
   assign w_rd = r_mem[w_idx];
   // W0 owns lanes o..7 of word w, W1 owns lanes 0..o-1 of word w+1
   assign w_mask = (r_state == W1) ? ~(~64'd0 << w_sh) : (~64'd0 << w_sh);
   assign w_wval = (r_state == W1) ? (r_wdata >> w_shc) : (r_wdata << w_sh);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (w_accept ? W0 : IDLE)
             : ((r_state == W0) && !r_err && w_split) ? W1 : IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_lo       <= '0;
         r_wr       <= 1'b0;
         r_err      <= 1'b0;
         valM       <= '0;
         done       <= 1'b0;
         dmem_error <= 1'b0;
      end else begin
         done       <= 1'b0;
         dmem_error <= 1'b0;
         if (w_accept) begin
            r_addr  <= addr[AW+2:0];
            r_wdata <= val_write;
            r_wr    <= wrEn;
            r_err   <= w_err;
         end
         if (r_state == W0) begin
            if (r_err) begin
               done       <= 1'b1;
               dmem_error <= 1'b1;
               valM       <= '0;
            end else if (w_split) begin
               r_lo <= w_rd >> w_sh;
            end else begin
               done <= 1'b1;
               if (!r_wr) valM <= w_rd;
            end
         end
         if (r_state == W1) begin
            done <= 1'b1;
            if (!r_wr) valM <= r_lo | (w_rd << w_shc);
         end
      end
   end
   // Memory is never reset; a reset during W1 leaves the W0 half written
   always_ff @(posedge clk) begin
      if (busy && !r_err && r_wr) r_mem[w_idx] <= (w_rd & ~w_mask) | (w_wval & w_mask);
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: table vectors, corner sequences and random traffic against a byte-level model
module tb_data_memory_ctrl;
   localparam int DEPTH = 1024;
   logic clk = 1'b0, reset = 1'b0, req = 1'b0, wrEn = 1'b0, reEn = 1'b0;
   logic [63:0] addr = '0, val_write = '0;
   logic [63:0] valM;
   logic done, busy, dmem_error;
   int total = 0, bad = 0;
   logic [7:0] mem_m [logic [63:0]];
   logic [63:0] m_val = '0;
   typedef struct {
      bit wr;
      bit re;
      logic [63:0] a;
      logic [63:0] d;
      logic [63:0] ev;
      bit ee;
      int el;
   } vec_t;
   vec_t tbl [11];

   data_memory_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .reset(reset), .req(req), .wrEn(wrEn), .reEn(reEn),
      .addr(addr), .val_write(val_write), .valM(valM), .done(done),
      .busy(busy), .dmem_error(dmem_error)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endfunction

   function automatic void model(input bit wr, input bit re, input logic [63:0] a, input logic [63:0] d,
                                 output logic [63:0] ev, output bit ee, output int el);
      logic [64:0] s;
      s = {1'b0, a} + 65'd7;
      ee = (wr && re) || (s >= 65'(DEPTH * 8));
`ifdef DMEM_ALIGN_CHECK_EN
      ee = ee || (a[2:0] != 3'd0);
`endif
      el = (ee || a[2:0] == 3'd0) ? 1 : 2;
      if (ee) m_val = '0;
      else if (wr) for (int k = 0; k < 8; k++) mem_m[a + 64'(k)] = d[8*k +: 8];
      else for (int k = 0; k < 8; k++) m_val[8*k +: 8] = mem_m[a + 64'(k)];
      ev = m_val;
   endfunction

   task automatic run(input bit wr, input bit re, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] v, output bit e, output int lat);
      @(negedge clk);
      req = 1'b1; wrEn = wr; reEn = re; addr = a; val_write = d;
      @(posedge clk);
      #1;
      req = 1'b0; wrEn = 1'b0; reEn = 1'b0;
      lat = 0; v = '0; e = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i; v = valM; e = dmem_error;
            break;
         end
      end
   endtask

   task automatic op_check(input string nm, input bit wr, input bit re, input logic [63:0] a,
                           input logic [63:0] d, input logic [63:0] ev, input bit ee, input int el);
      logic [63:0] v;
      bit e;
      int lat;
      run(wr, re, a, d, v, e, lat);
      chk({nm, "_lat"}, 64'(lat), 64'(el));
      chk({nm, "_err"}, 64'(e), 64'(ee));
      chk({nm, "_valM"}, v, ev);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      chk({nm, "_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic model_check(input string nm, input bit wr, input bit re, input logic [63:0] a,
                              input logic [63:0] d);
      logic [63:0] ev;
      bit ee;
      int el;
      model(wr, re, a, d, ev, ee, el);
      op_check(nm, wr, re, a, d, ev, ee, el);
   endtask

   initial begin
      logic [63:0] ev, a, d;
      bit ee, wr, re;
      int el, n, lat;
      tbl[0]  = '{1, 0, 64'h40, 64'h0123456789ABCDEF, 64'h0, 0, 1};
      tbl[1]  = '{0, 1, 64'h40, 64'h0, 64'h0123456789ABCDEF, 0, 1};
      tbl[2]  = '{1, 0, 64'h43, 64'h1122334455667788, 64'h0123456789ABCDEF, 0, 2};
      tbl[3]  = '{0, 1, 64'h43, 64'h0, 64'h1122334455667788, 0, 2};
      tbl[4]  = '{0, 1, 64'h40, 64'h0, 64'h4455667788ABCDEF, 0, 1};
      tbl[5]  = '{1, 0, 64'h1FF8, 64'hA5A5_5A5A_C3C3_3C3C, 64'h4455667788ABCDEF, 0, 1};
      tbl[6]  = '{1, 0, 64'h1FFC, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1, 1};
      tbl[7]  = '{0, 1, 64'h1FF8, 64'h0, 64'hA5A5_5A5A_C3C3_3C3C, 0, 1};
      tbl[8]  = '{1, 1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1};
      tbl[9]  = '{0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1, 1};
      tbl[10] = '{0, 1, 64'h40, 64'h0, 64'h4455667788ABCDEF, 0, 1};
      #12;
      chk("rst_valM", valM, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(dmem_error), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
`ifndef DMEM_ALIGN_CHECK_EN
      for (int i = 0; i < 11; i++) begin
         op_check($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].re, tbl[i].a, tbl[i].d, tbl[i].ev, tbl[i].ee, tbl[i].el);
         model(tbl[i].wr, tbl[i].re, tbl[i].a, tbl[i].d, ev, ee, el);
      end
`else
      model_check("al_st", 1, 0, 64'h40, 64'h0123456789ABCDEF);
      @(negedge clk);
      req = 1'b1; reEn = 1'b1; addr = 64'h43;
      @(posedge clk);
      #1;
      req = 1'b0; reEn = 1'b0;
      chk("al_busy0", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      chk("al_done", 64'(done), 64'd1);
      chk("al_err", 64'(dmem_error), 64'd1);
      chk("al_valM", valM, 64'd0);
      chk("al_busy1", 64'(busy), 64'd0);
      m_val = '0;
`endif
      for (int i = 0; i < 64; i++) model_check("init", 1, 0, 64'(i * 8), {$urandom(), $urandom()});
      for (int i = 0; i < 200; i++) begin
         n = $urandom_range(0, 15);
         wr = 1'($urandom_range(0, 1));
         re = !wr;
         a = 64'($urandom_range(0, 'h1F8));
         if (n == 0) a = 64'(DEPTH * 8 - $urandom_range(1, 7));
         else if (n == 1) a = {32'hFFFF_FFFF, $urandom()};
         else if (n == 2) begin wr = 1; re = 1; end
         d = {$urandom(), $urandom()};
         model_check("rand", wr, re, a, d);
      end
`ifndef DMEM_ALIGN_CHECK_EN
      d = 64'hFFEE_DDCC_BBAA_9988;
      @(negedge clk);
      req = 1'b1; wrEn = 1'b1; addr = 64'h45; val_write = d;
      @(posedge clk);
      #1;
      req = 1'b0;
      n = 0; lat = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) begin req = 1'b1; addr = 64'h80; val_write = 64'h1357_9BDF_2468_ACE0; end
         if (i == 3) begin req = 1'b0; wrEn = 1'b0; end
         @(posedge clk);
         #1;
         if (done) begin n++; if (lat == 0) lat = i; end
      end
      chk("busy_req_ndone", 64'(n), 64'd1);
      chk("busy_req_lat", 64'(lat), 64'd2);
      model(1, 0, 64'h45, d, ev, ee, el);
      model_check("busy_ld80", 0, 1, 64'h80, 64'h0);
      model_check("busy_ld45", 0, 1, 64'h45, 64'h0);
      d = 64'h0F1E_2D3C_4B5A_6978;
      @(negedge clk);
      req = 1'b1; wrEn = 1'b1; addr = 64'h41; val_write = d;
      @(posedge clk);
      #1;
      req = 1'b0; wrEn = 1'b0;
      @(posedge clk);
      chk("w1_busy_before", 64'(busy), 64'd1);
      #2;
      req = 1'b1; wrEn = 1'b1;
      reset = 1'b0;
      #1;
      chk("w1rst_valM", valM, 64'd0);
      chk("w1rst_done", 64'(done), 64'd0);
      chk("w1rst_busy", 64'(busy), 64'd0);
      chk("w1rst_err", 64'(dmem_error), 64'd0);
      @(posedge clk);
      #1;
      chk("w1rst_hold_busy", 64'(busy), 64'd0);
      @(negedge clk);
      req = 1'b0; wrEn = 1'b0;
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (done) n++;
      end
      chk("w1rst_nodone", 64'(n), 64'd0);
      for (int k = 0; k < 7; k++) mem_m[64'h41 + 64'(k)] = d[8*k +: 8];
      m_val = '0;
      model_check("w1rst_ld40", 0, 1, 64'h40, 64'h0);
      model_check("w1rst_ld48", 0, 1, 64'h48, 64'h0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
